// File: rtl/tag_link_arbiter_if.sv
// tag_link_arbiter_if: request/grant/data bundle between the lv1a/lv1b tag sources and the tag link arbiter.
interface tag_link_arbiter_if;
    logic        in_live;
    logic        req_a;
    logic        req_b;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [15:0] out_trig_tag;
    logic        out_tag_valid;
    logic        busy;
    logic [19:0] grant_cnt_a;
    logic [19:0] grant_cnt_b;
    logic [15:0] wait_cnt;
    modport master (
        output in_live, req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, out_trig_tag, out_tag_valid, busy, grant_cnt_a, grant_cnt_b, wait_cnt
    );
    modport slave (
        input  in_live, req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, out_trig_tag, out_tag_valid, busy, grant_cnt_a, grant_cnt_b, wait_cnt
    );
endinterface

// File: rtl/tag_link_arbiter.sv
// tag_link_arbiter: serialises lv1a/lv1b tag frames onto the trigger tag ADC link with a guard gap.
// Define TAG_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round-robin.
module tag_link_arbiter #(
    parameter int NWORD = 9,
    parameter int GAP   = 2
) (
    input logic clk,
    input logic rst,
    tag_link_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
    state_t      state, state_n;
    logic [3:0]  wcnt, wcnt_n;
    logic [2:0]  gcnt, gcnt_n;
    logic        last_b, last_b_n, live_q, pick_a, rise, waiting;
    logic        gnt_a_n, gnt_b_n, valid_n;
    logic [15:0] tag_n, wbase;
    assign rise    = bus.in_live & ~live_q;
    assign waiting = bus.in_live & ((bus.req_a & ~bus.gnt_a) | (bus.req_b & ~bus.gnt_b));
    assign wbase   = rise ? 16'd0 : bus.wait_cnt;
    assign bus.busy = state != S_IDLE;
`ifdef TAG_ARB_FIXED_PRIO_EN
    assign pick_a = bus.req_a;
`else
    assign pick_a = bus.req_a & (~bus.req_b | last_b);
`endif
    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        gcnt_n   = gcnt;
        last_b_n = last_b;
        gnt_a_n  = bus.gnt_a;
        gnt_b_n  = bus.gnt_b;
        tag_n    = 16'd0;
        valid_n  = 1'b0;
        if (!bus.in_live) begin
            state_n = S_IDLE;
            gnt_a_n = 1'b0;
            gnt_b_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_a | bus.req_b) begin
                    gnt_a_n  = pick_a;
                    gnt_b_n  = ~pick_a;
                    last_b_n = ~pick_a;
                    wcnt_n   = 4'd0;
                    state_n  = S_SEND;
                end
                S_SEND: begin
                    tag_n   = bus.gnt_a ? bus.data_a : bus.data_b;
                    valid_n = 1'b1;
                    wcnt_n  = wcnt + 4'd1;
                    if (wcnt == 4'(NWORD - 1)) begin
                        gnt_a_n = 1'b0;
                        gnt_b_n = 1'b0;
                        gcnt_n  = 3'd0;
                        state_n = S_GAP;
                    end
                end
                S_GAP: begin
                    gcnt_n  = gcnt + 3'd1;
                    state_n = gcnt == 3'(GAP - 1) ? S_IDLE : S_GAP;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
    // Grants only rise out of IDLE, so a rising grant marks the clock a frame is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            wcnt              <= 4'd0;
            gcnt              <= 3'd0;
            last_b            <= 1'b1;
            live_q            <= 1'b0;
            bus.gnt_a         <= 1'b0;
            bus.gnt_b         <= 1'b0;
            bus.out_trig_tag  <= 16'd0;
            bus.out_tag_valid <= 1'b0;
            bus.grant_cnt_a   <= 20'd0;
            bus.grant_cnt_b   <= 20'd0;
            bus.wait_cnt      <= 16'd0;
        end else begin
            state             <= state_n;
            wcnt              <= wcnt_n;
            gcnt              <= gcnt_n;
            last_b            <= last_b_n;
            live_q            <= bus.in_live;
            bus.gnt_a         <= gnt_a_n;
            bus.gnt_b         <= gnt_b_n;
            bus.out_trig_tag  <= tag_n;
            bus.out_tag_valid <= valid_n;
            bus.grant_cnt_a   <= (rise ? 20'd0 : bus.grant_cnt_a) + 20'(gnt_a_n & ~bus.gnt_a);
            bus.grant_cnt_b   <= (rise ? 20'd0 : bus.grant_cnt_b) + 20'(gnt_b_n & ~bus.gnt_b);
            bus.wait_cnt      <= wbase + 16'(waiting && wbase != 16'hFFFF);
        end
    end
endmodule

// File: doc/tag_link_arbiter.md
# tag_link_arbiter

Arbitrates the single 16-bit trigger tag ADC link between two tag frame sources: port A (lv1a tag stream) and port B (lv1b tag stream). Each source requests, receives a grant, and streams a fixed-length frame one word per clock. The arbiter serialises the frames onto `out_trig_tag` and inserts a guard gap between frames. It also keeps per-port grant and contention statistics for the run-control readout. It sits between the lv1a/lv1b pipelines and the trigger tag ADC LVDS output.

## Interface
- `NWORD`, 9: words per tag frame (header through ET raw); legal range 2–15.
- `GAP`, 2: idle clocks inserted after each frame; legal range 1–7.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_live` in 1: run live; low aborts the current frame and holds the arbiter idle.
- `req_a` in 1: port A frame request; must be held until `gnt_a`.
- `data_a` in 16: port A frame word, driven by the source while `gnt_a`=1.
- `req_b` in 1: port B frame request.
- `data_b` in 16: port B frame word.
- `gnt_a` out 1: port A grant; high for exactly `NWORD` consecutive clocks.
- `gnt_b` out 1: port B grant; same rule as `gnt_a`.
- `out_trig_tag` out 16: serialised tag word to the ADC; 0 when not valid.
- `out_tag_valid` out 1: `out_trig_tag` carries a frame word.
- `busy` out 1: state is not IDLE.
- `grant_cnt_a` out 20: frames granted to A; wraps.
- `grant_cnt_b` out 20: frames granted to B; wraps.
- `wait_cnt` out 16: contention clocks; saturates at 0xFFFF.

## Operation
- Reset values: every output is 0; state is IDLE; the last-served pointer is B, so A wins the first contention.
- FSM states are IDLE, SEND and GAP.
- IDLE: if `in_live`=1 and any request is high, pick a winner, assert its grant, clear the word counter and go to SEND. Otherwise stay in IDLE.
- Winner selection:
  - Only one request high: that port wins.
  - Both high: the port not last served wins (round-robin).
  - The last-served pointer updates on every grant.
- SEND: on each clock the granted port's `data_x` is registered into `out_trig_tag` with `out_tag_valid`=1.
  - The word counter increments each clock.
  - After `NWORD` words: drop the grant, clear the gap counter, go to GAP.
- GAP: `out_tag_valid`=0 and `out_trig_tag`=0 for `GAP` clocks, then go to IDLE.
- A request deasserting during SEND does not shorten the frame; exactly `NWORD` words are always sent.
- The granted port's request is ignored until the FSM returns to IDLE.
- `grant_cnt_x` increments by 1 in the clock the grant is issued.
- `wait_cnt` increments by 1 per clock in which at least one request is high and that port's grant is low; otherwise it holds. It counts one per clock even when both ports wait.
- `in_live`=0, synchronous abort:
  - Next edge: state goes to IDLE and grants, valid and data all go to 0.
  - The pointer and counters hold.
  - A partially sent frame is truncated; the ADC side discards it by header.
- `in_live` rising edge (previous-cycle value 0, current value 1): clear `grant_cnt_a`, `grant_cnt_b` and `wait_cnt`.
- `rst` mid-frame: immediate return to reset values.

## Timing
- A request sampled high in IDLE at edge e0 gives grant high after e0.
- Word k is sampled at edge e1+k (k = 0..`NWORD`-1).
- First valid word appears after e1: request-to-first-word latency is 2 clocks.
- The grant is high for `NWORD` clocks. `out_tag_valid` is the grant delayed by one clock.
- Back-to-back frame period is 1 + `NWORD` + `GAP` clocks (12 at defaults).
- Worst-case wait for a held request under contention is one full period.

## Configuration
- `TAG_ARB_FIXED_PRIO_EN`:
  - Defined: port A always wins contention; the pointer is unused; port B is served only when `req_a`=0 in IDLE.
  - Undefined: round-robin as above.

## Test plan
- Single A frame, `data_a`=0xEEEE then 1..8: `gnt_a` high 9 clocks, `out_trig_tag` reproduces the 9 words starting 2 clocks after `req_a`, 2 idle clocks, `grant_cnt_a`=1.
- `req_a` and `req_b` both held after reset: order is A,B,A,B; period 12 clocks; `wait_cnt` increments 12 per frame while the other port waits.
- Same stimulus with `TAG_ARB_FIXED_PRIO_EN`: only A is served while `req_a` is held; B is served once `req_a` drops; `wait_cnt` increments every clock B waits.
- `req_b` pulses for 1 clock at grant and then drops: the full 9-word frame is still sent; `grant_cnt_b`=1.
- `in_live` dropped at word 4 of an A frame: the next clock shows `gnt_a`=0, `out_tag_valid`=0 and counters held. `in_live` rising again clears the counters to 0.
- `rst` asserted mid-SEND: all outputs 0 immediately. After release the FSM is in IDLE and A wins the first contention.
